uart_boot_loader: RTL and testbench

UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

---
 rtl/uart_boot_pkg.sv | 18 +
 rtl/uart_boot_loader.sv | 135 +++++++++++++
 tb/tb_uart_boot_loader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_boot_pkg.sv
// Shared frame-parser states and sync byte values for the UART boot loader.
// Pure declarations; no logic, no latency, no flow control.
package uart_boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM
  } state_t;

  localparam logic [7:0] SYNC_LOAD = 8'hA5;
  localparam logic [7:0] SYNC_RUN  = 8'h5A;

endpackage

// File: rtl/uart_boot_loader.sv
// Parses A5 load frames from a UART byte stream into 32-bit RAM writes; 5A releases the core.
// ram_we follows the 4th byte of a word by one cycle; no backpressure, a byte may arrive every cycle.
module uart_boot_loader
  import uart_boot_pkg::*;
#(
  parameter int ADDR_W      = 13,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_data,
  output logic              ram_we,
  output logic              core_run,
  output logic              busy,
  output logic              err
);

  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_t            state;
  state_t            nxt;
  logic [TO_W-1:0]   idle_cnt;
  logic [7:0]        addr_hi;
  logic [7:0]        len_hi;
  logic [15:0]       words_left;
  logic [1:0]        lane;
  logic [23:0]       word_buf;
  logic [7:0]        csum;
  logic              timeout;

  assign busy    = (state != IDLE);
  assign timeout = busy && !rx_valid && (idle_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (timeout) begin
      nxt = IDLE;
    end else if (rx_valid) begin
      case (state)
        IDLE:    if (rx_data == SYNC_LOAD) nxt = ADDR_HI;
        ADDR_HI: nxt = ADDR_LO;
        ADDR_LO: nxt = LEN_HI;
        LEN_HI:  nxt = LEN_LO;
        LEN_LO:  nxt = ({len_hi, rx_data} == 16'd0) ? CSUM : DATA;
        DATA:    if (lane == 2'd3 && words_left == 16'd1) nxt = CSUM;
        CSUM:    nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_addr   <= '0;
      ram_data   <= '0;
      ram_we     <= 1'b0;
      core_run   <= 1'b0;
      err        <= 1'b0;
      idle_cnt   <= '0;
      addr_hi    <= '0;
      len_hi     <= '0;
      words_left <= '0;
      lane       <= '0;
      word_buf   <= '0;
      csum       <= '0;
    end else begin
      ram_we <= 1'b0;
      // Post-increment after each write; a new ADDR_LO below overrides it.
      if (ram_we) ram_addr <= ram_addr + ADDR_W'(1);

      if (!busy || rx_valid || timeout) idle_cnt <= '0;
      else                              idle_cnt <= idle_cnt + TO_W'(1);

      if (timeout) begin
        err <= 1'b1;
      end else if (rx_valid) begin
        case (state)
          IDLE: begin
            if (rx_data == SYNC_LOAD) begin
              err  <= 1'b0;
              csum <= '0;
              lane <= '0;
            end else if (rx_data == SYNC_RUN) begin
              core_run <= 1'b1;
            end
          end
          ADDR_HI: begin
            addr_hi <= rx_data;
            csum    <= csum ^ rx_data;
          end
          ADDR_LO: begin
            ram_addr <= ADDR_W'({addr_hi, rx_data});
            csum     <= csum ^ rx_data;
          end
          LEN_HI: begin
            len_hi <= rx_data;
            csum   <= csum ^ rx_data;
          end
          LEN_LO: begin
            words_left <= {len_hi, rx_data};
            lane       <= '0;
            csum       <= csum ^ rx_data;
          end
          DATA: begin
            csum <= csum ^ rx_data;
            lane <= lane + 2'd1;
            case (lane)
              2'd0:    word_buf[7:0]   <= rx_data;
              2'd1:    word_buf[15:8]  <= rx_data;
              2'd2:    word_buf[23:16] <= rx_data;
              default: begin
                ram_data   <= {rx_data, word_buf};
                ram_we     <= 1'b1;
                words_left <= words_left - 16'd1;
              end
            endcase
          end
          CSUM: begin
            if (rx_data != csum) err <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboarded bench: frames are built from a byte-level model, expected writes are queued as bytes are
// issued, and a negedge monitor checks every ram_we against the queue.
module tb_uart_boot_loader;

  localparam int AW = 13;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_data;
  logic          ram_we;
  logic          core_run;
  logic          busy;
  logic          err;

  always #5 clk = ~clk;

  uart_boot_loader #(.ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_we   (ram_we),
    .core_run (core_run),
    .busy     (busy),
    .err      (err)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            cyc;
  } wr_t;

  wr_t         sb[$];
  wr_t         pend[$];
  wr_t         mon_e;
  logic [7:0]  tx_q[$];
  bit          word_end[$];
  logic [31:0] wq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ram_we) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected", ram_addr, ram_data);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_addr", 32'(ram_addr), 32'(mon_e.addr));
        chk("wr_data", ram_data, mon_e.data);
        chk("wr_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Frame = A5, addr16, len16, words little-endian, csum; csum = XOR of all bytes after A5, then ^ flip.
  task automatic build_frame(input logic [15:0] a16, input logic [7:0] flip, output bit exp_err);
    logic [7:0]  cs;
    logic [15:0] n16;
    logic [7:0]  hdr[4];
    wr_t         w;
    n16 = 16'(wq.size());
    tx_q.delete(); word_end.delete(); pend.delete();
    tx_q.push_back(8'hA5); word_end.push_back(1'b0);
    hdr[0] = a16[15:8]; hdr[1] = a16[7:0]; hdr[2] = n16[15:8]; hdr[3] = n16[7:0];
    cs = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tx_q.push_back(hdr[i]); word_end.push_back(1'b0); cs ^= hdr[i];
    end
    for (int i = 0; i < wq.size(); i++) begin
      for (int b = 0; b < 4; b++) begin
        tx_q.push_back(wq[i][8*b +: 8]);
        word_end.push_back(b == 3);
        cs ^= wq[i][8*b +: 8];
      end
      w.addr = AW'((int'(a16) + i) % (1 << AW));
      w.data = wq[i];
      w.cyc  = 0;
      pend.push_back(w);
    end
    tx_q.push_back(cs ^ flip); word_end.push_back(1'b0);
    exp_err = (flip != 8'h00);
  endtask

  task automatic send_tx(input bit b2b, input int nbytes);
    wr_t e;
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk);
      rx_data  = tx_q[i];
      rx_valid = 1'b1;
      if (word_end[i]) begin
        e = pend.pop_front();
        e.cyc = cyc + 1;
        sb.push_back(e);
      end
      if (!b2b) begin
        @(negedge clk);
        rx_valid = 1'b0;
        repeat ($urandom_range(0, 4)) @(negedge clk);
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic run_frame(input string name, input logic [15:0] a16, input logic [7:0] flip, input bit b2b);
    bit exp_err;
    build_frame(a16, flip, exp_err);
    send_tx(b2b, tx_q.size());
    repeat (3) @(negedge clk);
    chk({name, "_drained"}, sb.size(), 0);
    chk({name, "_err"}, 32'(err), 32'(exp_err));
    chk({name, "_busy"}, 32'(busy), 0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_addr"}, 32'(ram_addr), 0);
    chk({name, "_data"}, ram_data, 0);
    chk({name, "_we"}, 32'(ram_we), 0);
    chk({name, "_run"}, 32'(core_run), 0);
    chk({name, "_busy"}, 32'(busy), 0);
    chk({name, "_err"}, 32'(err), 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit dummy;
    logic [7:0] flip;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // 0x5A inside DATA is payload, not a run command
    wq = '{32'h5A5A5A5A};
    run_frame("data5a", 16'h0200, 8'h00, 1'b0);
    chk("data5a_run", 32'(core_run), 0);

    // Body XOR of 00 10 00 01 11 22 33 44 is 0x55
    wq = '{32'h44332211};
    run_frame("basic", 16'h0010, 8'h00, 1'b0);
    // 0x55 ^ 0x47 = 0x12 on the wire
    wq = '{32'h44332211};
    run_frame("badcsum", 16'h0010, 8'h47, 1'b0);

    wq = '{$urandom, $urandom};
    run_frame("wrap", 16'h1FFF, 8'h00, 1'b1);

    wq.delete();
    run_frame("len0", 16'h0123, 8'h00, 1'b1);

    // Timeout after A5 00 00
    wq = '{$urandom};
    build_frame(16'h0000, 8'h00, dummy);
    send_tx(1'b1, 3);
    pend.delete();
    repeat (TO - 1) @(posedge clk);
    @(negedge clk);
    chk("to_busy_before", 32'(busy), 1);
    chk("to_err_before", 32'(err), 0);
    @(posedge clk);
    @(negedge clk);
    chk("to_busy_after", 32'(busy), 0);
    chk("to_err_after", 32'(err), 1);
    repeat (3) @(negedge clk);
    chk("to_drained", sb.size(), 0);

    tx_q = '{8'h5A}; word_end = '{1'b0};
    chk("run_before", 32'(core_run), 0);
    send_tx(1'b1, 1);
    chk("run_after", 32'(core_run), 1);
    chk("run_busy", 32'(busy), 0);

    for (int k = 0; k < 8; k++) begin
      wq.delete();
      repeat ($urandom_range(0, 3)) wq.push_back($urandom);
      flip = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_frame("rand", 16'($urandom), flip, 1'($urandom_range(0, 1)));
      chk("rand_run_sticky", 32'(core_run), 1);
    end

    // Reset after two data bytes of a frame
    wq = '{$urandom, $urandom};
    build_frame(16'h0100, 8'h00, dummy);
    send_tx(1'b1, 7);
    pend.delete();
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_drained", sb.size(), 0);
    wq = '{$urandom, $urandom, $urandom};
    run_frame("afterrst", 16'h0ABC, 8'h00, 1'b0);
    chk("afterrst_run", 32'(core_run), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
